// File: rtl/jtdsp16_pkg.sv
// Shared constants for the DSP16 do/redo instruction cache.
package jtdsp16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } cache_state_t;

  localparam int CACHE_DEPTH = 15;

  // do_data field positions
  localparam int NI_MSB = 10;
  localparam int NI_LSB = 7;
  localparam int K_MSB  = 6;
  localparam int K_LSB  = 0;

  // A repeat count of zero behaves like a single pass.
  function automatic logic [6:0] k_floor1(input logic [6:0] k);
    return (k == 7'd0) ? 7'd1 : k;
  endfunction

endpackage

// File: rtl/jtdsp16_do_cache_if.sv
// Bus between the sequencer/ROM side and the do-loop cache.
interface jtdsp16_do_cache_if;
  logic        do_start;
  logic [10:0] do_data;
  logic        fetch_en;
  logic [15:0] rom_dout;
  logic [15:0] cache_dout;
  logic        cache_sel;
  logic        pc_hold;
  logic        busy;
  logic        loop_done;

  modport master (
    output do_start, do_data, fetch_en, rom_dout,
    input  cache_dout, cache_sel, pc_hold, busy, loop_done
  );

  modport slave (
    input  do_start, do_data, fetch_en, rom_dout,
    output cache_dout, cache_sel, pc_hold, busy, loop_done
  );
endinterface

// File: rtl/jtdsp16_do_cache.sv
// do/redo loop cache: captures the loop body on the first pass and replays
// it from local flops for the remaining passes while holding the PC.
module jtdsp16_do_cache
  import jtdsp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  jtdsp16_do_cache_if.slave bus
);

  cache_state_t state, nxt;

  logic [15:0] mem [CACHE_DEPTH];
  logic [3:0]  ni_r;
  logic [6:0]  k_r;
  logic [6:0]  iter;
  logic [3:0]  ptr;
  logic        loop_done_r;

  logic [3:0]  do_ni;
  logic [6:0]  do_k;
  logic        last;
  logic        fill_end;
  logic        replay_end;
  logic        done_cond;

  assign do_ni = bus.do_data[NI_MSB:NI_LSB];
  assign do_k  = bus.do_data[K_MSB:K_LSB];

  // ptr sits on the final body word; ni_r is never 0 outside IDLE
  assign last       = (ptr == ni_r - 4'd1);
  assign fill_end   = (state == FILL)   && bus.fetch_en && last;
  assign replay_end = (state == REPLAY) && bus.fetch_en && last;
  assign done_cond  = (fill_end && (k_r == 7'd1)) || (replay_end && (iter == 7'd1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (cen) state <= nxt;
  end

  // next-state decode; do_start outside IDLE is dropped (no nesting)
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (bus.do_start) begin
          if (do_ni != 4'd0)      nxt = FILL;
          else if (ni_r != 4'd0)  nxt = REPLAY;
        end
      end
      FILL:    if (fill_end) nxt = (k_r == 7'd1) ? IDLE : REPLAY;
      REPLAY:  if (replay_end && (iter == 7'd1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs: replayed word is a combinational read so it tracks ptr in-cycle
  always_comb begin
    bus.cache_sel  = (state == REPLAY);
    bus.pc_hold    = (state == REPLAY);
    bus.busy       = (state != IDLE);
    bus.loop_done  = loop_done_r;
    bus.cache_dout = mem[ptr];
  end

  // loop counters, body length/count latches and the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ni_r        <= 4'd0;
      k_r         <= 7'd0;
      iter        <= 7'd0;
      ptr         <= 4'd0;
      loop_done_r <= 1'b0;
    end else if (cen) begin
      loop_done_r <= done_cond;
      case (state)
        IDLE: begin
          if (bus.do_start) begin
            if (do_ni != 4'd0) begin
              ni_r <= do_ni;
              k_r  <= k_floor1(do_k);
              ptr  <= 4'd0;
            end else if (ni_r != 4'd0) begin
              iter <= k_floor1(do_k);
              ptr  <= 4'd0;
            end
          end
        end
        FILL: begin
          if (bus.fetch_en) begin
            if (!last) begin
              ptr <= ptr + 4'd1;
            end else if (k_r != 7'd1) begin
              // first pass already consumed one of the K passes
              iter <= k_r - 7'd1;
              ptr  <= 4'd0;
            end
          end
        end
        REPLAY: begin
          if (bus.fetch_en) begin
            if (!last) begin
              ptr <= ptr + 4'd1;
            end else if (iter != 7'd1) begin
              iter <= iter - 7'd1;
              ptr  <= 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // body capture during the first pass; contents survive for redo
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CACHE_DEPTH; i++) mem[i] <= 16'h0;
    end else if (cen && (state == FILL) && bus.fetch_en) begin
      mem[ptr] <= bus.rom_dout;
    end
  end

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Self-checking bench for jtdsp16_do_cache: table of loops plus reset and
// idle-redo sequences, checked against a word-stream model.
module tb_jtdsp16_do_cache;

  logic clk, rst, cen;
  jtdsp16_do_cache_if dif();

  jtdsp16_do_cache dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model state: what the cache should hold for a later redo
  logic [15:0] mmem [15];
  int          mni;

  typedef struct {
    int ni;
    int k;
    bit gaps;
    int inject_at;
    int total;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dout"}, 32'(dif.cache_dout), 32'h0);
    chk({tag, "_sel"},  32'(dif.cache_sel),  32'h0);
    chk({tag, "_hold"}, 32'(dif.pc_hold),    32'h0);
    chk({tag, "_busy"}, 32'(dif.busy),       32'h0);
    chk({tag, "_done"}, 32'(dif.loop_done),  32'h0);
  endtask

  // Runs one do (ni>0) or redo (ni==0) loop. Entered and left at posedge+1.
  task automatic run_loop(input int ni, input int k, input bit gaps,
                          input int inject_at, input int abort_at, input int total);
    bit          redo;
    int          cur_ni, n, cyc;
    logic [15:0] body [15];
    logic [15:0] consumed;
    redo   = (ni == 0);
    cur_ni = redo ? mni : ni;
    for (int i = 0; i < 15; i++) body[i] = redo ? mmem[i] : 16'($urandom);

    dif.do_start = 1'b1;
    dif.do_data  = {4'(ni), 7'(k)};
    cen          = 1'b1;
    dif.fetch_en = 1'b1;
    @(posedge clk); #1;
    dif.do_start = 1'b0;
    if (!redo) begin
      mni = ni;
      for (int i = 0; i < 15; i++) mmem[i] = (i < ni) ? body[i] : mmem[i];
    end

    n = 0; cyc = 0;
    while (n < total && cyc < 20000) begin
      cen          = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      dif.fetch_en = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      dif.rom_dout = (!redo && n < cur_ni) ? body[n] : 16'($urandom);
      if (n == inject_at) begin
        dif.do_start = 1'b1;
        dif.do_data  = {4'd2, 7'd3};
        cen          = 1'b1;
      end else begin
        dif.do_start = 1'b0;
      end
      @(negedge clk);
      chk("busy_in_loop", 32'(dif.busy), 32'h1);
      chk("done_early",   32'(dif.loop_done), 32'h0);
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        chk_outputs_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        dif.do_start = 1'b0;
        cen = 1'b0;
        dif.fetch_en = 1'b0;
        mni = 0;
        for (int i = 0; i < 15; i++) mmem[i] = 16'h0;
        return;
      end
      if (cen && dif.fetch_en) begin
        consumed = dif.cache_sel ? dif.cache_dout : dif.rom_dout;
        chk("word",    32'(consumed), 32'(body[n % cur_ni]));
        chk("sel",     32'(dif.cache_sel), 32'(redo || n >= cur_ni));
        chk("pc_hold", 32'(dif.pc_hold),   32'(redo || n >= cur_ni));
        n++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    dif.do_start = 1'b0;
    chk("word_count", 32'(n), 32'(total));
    chk("done_pulse", 32'(dif.loop_done), 32'h1);
    chk("busy_end",   32'(dif.busy),      32'h0);
    chk("sel_end",    32'(dif.cache_sel), 32'h0);
    chk("hold_end",   32'(dif.pc_hold),   32'h0);
    cen = 1'b1;
    dif.fetch_en = 1'b0;
    @(posedge clk); #1;
    chk("done_single", 32'(dif.loop_done), 32'h0);
  endtask

  // A redo issued with no captured body must produce no activity.
  task automatic chk_ignored_redo(input int k);
    dif.do_start = 1'b1;
    dif.do_data  = {4'd0, 7'(k)};
    cen          = 1'b1;
    dif.fetch_en = 1'b0;
    @(posedge clk); #1;
    dif.do_start = 1'b0;
    repeat (3) begin
      dif.fetch_en = 1'b1;
      dif.rom_dout = 16'($urandom);
      @(negedge clk);
      chk("ign_busy", 32'(dif.busy),      32'h0);
      chk("ign_sel",  32'(dif.cache_sel), 32'h0);
      chk("ign_hold", 32'(dif.pc_hold),   32'h0);
      chk("ign_done", 32'(dif.loop_done), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // ni, k, gaps, inject_at, expected words (NI x max(K,1); redo uses last NI)
    vecs[0]  = '{3,  4,   1'b0, -1, 12};
    vecs[1]  = '{0,  5,   1'b0, -1, 15};
    vecs[2]  = '{2,  1,   1'b0, -1, 2};
    vecs[3]  = '{2,  0,   1'b0, -1, 2};
    vecs[4]  = '{3,  4,   1'b1, -1, 12};
    vecs[5]  = '{0,  0,   1'b0, -1, 3};
    vecs[6]  = '{15, 127, 1'b0, -1, 1905};
    vecs[7]  = '{0,  2,   1'b0, -1, 30};
    vecs[8]  = '{1,  3,   1'b1, -1, 3};
    vecs[9]  = '{4,  2,   1'b1, 6,  8};
    vecs[10] = '{0,  1,   1'b1, -1, 4};

    mni = 0;
    for (int i = 0; i < 15; i++) mmem[i] = 16'h0;

    rst          = 1'b1;
    cen          = 1'b0;
    dif.do_start = 1'b0;
    dif.do_data  = 11'h0;
    dif.fetch_en = 1'b0;
    dif.rom_dout = 16'h0;
    #3;
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    chk_ignored_redo(5);

    for (int v = 0; v < 11; v++)
      run_loop(vecs[v].ni, vecs[v].k, vecs[v].gaps, vecs[v].inject_at, -1, vecs[v].total);

    // reset during REPLAY, then a redo that must be ignored
    run_loop(3, 4, 1'b0, -1, 7, 12);
    chk_ignored_redo(5);

    // a fresh loop still works after the abort
    run_loop(2, 3, 1'b1, -1, -1, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
